// File: rtl/mollerti_arb_pkg.sv
// Shared types and constants for the mollerTI register arbiter.
package mollerti_arb_pkg;

   localparam int NUM_REQ = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_AW_W,
      ST_WR_B,
      ST_RD_AR,
      ST_RD_R,
      ST_DONE
   } arb_state_e;

endpackage

// File: rtl/mollerti_reg_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant,
   output logic       valid
);

   always_comb begin
      grant = 2'b00;
      valid = |req;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mollerti_reg_arbiter.sv
// Round-robin arbiter sharing the mollerTI AXI4-Lite register slave between two
// req/ack requesters, one AXI transaction outstanding at a time.
//
// state      | meaning
// IDLE       | wait for a request, arbitrate, latch granted payload
// WR_AW_W    | AWVALID/WVALID up, each drops on its own handshake
// WR_B       | BREADY up, wait for write response
// RD_AR      | ARVALID up until ARREADY
// RD_R       | RREADY up, capture RDATA on RVALID
// DONE       | one-cycle ack to the granted requester
module mollerti_reg_arbiter
   import mollerti_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                                ACLK,
   input  logic                                ARESETN,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ-1:0]                  req_we,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]                  ack,
   output logic [DATA_WIDTH-1:0]               rdata,
   output logic                                err,
   output logic                                busy,
   output logic [ADDR_WIDTH-1:0]               M_AXI_AWADDR,
   output logic [2:0]                          M_AXI_AWPROT,
   output logic                                M_AXI_AWVALID,
   input  logic                                M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]               M_AXI_WDATA,
   output logic [3:0]                          M_AXI_WSTRB,
   output logic                                M_AXI_WVALID,
   input  logic                                M_AXI_WREADY,
   input  logic [1:0]                          M_AXI_BRESP,
   input  logic                                M_AXI_BVALID,
   output logic                                M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]               M_AXI_ARADDR,
   output logic [2:0]                          M_AXI_ARPROT,
   output logic                                M_AXI_ARVALID,
   input  logic                                M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]               M_AXI_RDATA,
   input  logic [1:0]                          M_AXI_RRESP,
   input  logic                                M_AXI_RVALID,
   output logic                                M_AXI_RREADY
);

   arb_state_e state_q, state_d;
   logic                  last_q, last_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d, ack_q, ack_d;
   logic                  err_q, err_d, busy_q;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic arvalid_q, arvalid_d, rready_q, rready_d;

   logic [NUM_REQ-1:0]    gnt;
   logic                  gnt_valid;
   logic                  sel_idx;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  unused_resp_lsb;

   rr_arb2 u_rr_arb2 (
      .req        (req),
      .last_grant (last_q),
      .grant      (gnt),
      .valid      (gnt_valid)
   );

   assign sel_idx   = gnt[1];
   assign sel_we    = req_we[sel_idx];
   assign sel_addr  = req_addr[sel_idx];
   assign sel_wdata = req_wdata[sel_idx];

   // Only the SLVERR/DECERR bit of the response matters here.
   assign unused_resp_lsb = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      grant_d   = grant_q;
      ack_d     = '0;
      err_d     = err_q;
      rdata_d   = rdata_q;
      awaddr_d  = awaddr_q;
      araddr_d  = araddr_q;
      wdata_d   = wdata_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               grant_d = gnt;
               last_d  = gnt[1];
               if (sel_addr[1:0] != 2'b00) begin
                  err_d   = 1'b1;
                  ack_d   = gnt;
                  state_d = ST_DONE;
               end else if (sel_we) begin
                  awaddr_d  = sel_addr;
                  wdata_d   = sel_wdata;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_WR_AW_W;
               end else begin
                  araddr_d  = sel_addr;
                  arvalid_d = 1'b1;
                  state_d   = ST_RD_AR;
               end
            end
         end
         ST_WR_AW_W: begin
            awvalid_d = awvalid_q & ~M_AXI_AWREADY;
            wvalid_d  = wvalid_q & ~M_AXI_WREADY;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = ST_WR_B;
            end
         end
         ST_WR_B: begin
            if (M_AXI_BVALID) begin
               bready_d = 1'b0;
               err_d    = M_AXI_BRESP[1];
               ack_d    = grant_q;
               state_d  = ST_DONE;
            end
         end
         ST_RD_AR: begin
            if (M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RD_R;
            end
         end
         ST_RD_R: begin
            if (M_AXI_RVALID) begin
               rready_d = 1'b0;
               rdata_d  = M_AXI_RDATA;
               err_d    = M_AXI_RRESP[1];
               ack_d    = grant_q;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q   <= ST_IDLE;
         last_q    <= 1'b1;
         grant_q   <= '0;
         ack_q     <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         rdata_q   <= '0;
         wdata_q   <= '0;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         busy_q    <= (state_d != ST_IDLE);
         rdata_q   <= rdata_d;
         wdata_q   <= wdata_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
      end
   end

   assign ack           = ack_q;
   assign rdata         = rdata_q;
   assign err           = err_q;
   assign busy          = busy_q;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_mollerti_reg_arbiter.sv
// Directed bench for mollerti_reg_arbiter with a small AXI4-Lite slave model.
module tb_mollerti_reg_arbiter;
   import mollerti_arb_pkg::*;

   logic            ACLK;
   logic            ARESETN;
   logic [1:0]      req, req_we;
   logic [1:0][3:0] req_addr;
   logic [1:0][31:0] req_wdata;
   logic [1:0]      ack;
   logic [31:0]     rdata;
   logic            err, busy;
   logic [3:0]      AWADDR, ARADDR;
   logic [2:0]      AWPROT, ARPROT;
   logic            AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic            ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0]     WDATA, RDATA;
   logic [3:0]      WSTRB;
   logic [1:0]      BRESP, RRESP;

   int n_cmp = 0;
   int n_err = 0;

   // slave model controls
   int unsigned aw_delay = 0;
   logic        slv_err  = 1'b0;

   mollerti_reg_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .ack(ack), .rdata(rdata), .err(err), .busy(busy),
      .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
      .M_AXI_AWREADY(AWREADY), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
      .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP),
      .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR),
      .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
      .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
      .M_AXI_RREADY(RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Slave: four registers, AWREADY held off aw_delay cycles, response one cycle after handshake.
   logic [31:0] sregs [4];
   logic        got_aw, got_w, aw_hs, w_hs, ar_hs;
   logic [3:0]  aw_addr_l, wr_addr;
   logic [31:0] wdata_l, wr_data;
   int unsigned aw_wait;

   assign AWREADY = (aw_wait >= aw_delay);
   assign WREADY  = 1'b1;
   assign ARREADY = 1'b1;
   assign aw_hs   = AWVALID & AWREADY;
   assign w_hs    = WVALID & WREADY;
   assign ar_hs   = ARVALID & ARREADY;
   assign wr_addr = aw_hs ? AWADDR : aw_addr_l;
   assign wr_data = w_hs ? WDATA : wdata_l;

   always @(posedge ACLK) begin
      if (!ARESETN) begin
         for (int i = 0; i < 4; i++) sregs[i] <= 32'h0;
         got_aw <= 1'b0; got_w <= 1'b0; aw_wait <= 0;
         aw_addr_l <= 4'h0; wdata_l <= 32'h0;
         BVALID <= 1'b0; BRESP <= RESP_OKAY;
         RVALID <= 1'b0; RRESP <= RESP_OKAY; RDATA <= 32'h0;
      end else begin
         aw_wait <= (AWVALID && !AWREADY) ? aw_wait + 1 : 0;
         if (aw_hs) aw_addr_l <= AWADDR;
         if (w_hs)  wdata_l   <= WDATA;
         if (BVALID && BREADY) BVALID <= 1'b0;
         if ((got_aw || aw_hs) && (got_w || w_hs)) begin
            sregs[wr_addr[3:2]] <= wr_data;
            got_aw <= 1'b0;
            got_w  <= 1'b0;
            BVALID <= 1'b1;
            BRESP  <= slv_err ? RESP_SLVERR : RESP_OKAY;
         end else begin
            if (aw_hs) got_aw <= 1'b1;
            if (w_hs)  got_w  <= 1'b1;
         end
         if (RVALID && RREADY) RVALID <= 1'b0;
         if (ar_hs) begin
            RVALID <= 1'b1;
            RDATA  <= slv_err ? 32'h12345678 : sregs[ARADDR[3:2]];
            RRESP  <= slv_err ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   // Issue one request from a negedge and wait (bounded) for any ack.
   task automatic run_txn(input int idx, input logic we, input logic [3:0] addr,
                          input logic [31:0] wd, output int lat, output logic [1:0] ackv,
                          output logic [31:0] rd, output logic e);
      req_we[idx] = we; req_addr[idx] = addr; req_wdata[idx] = wd; req[idx] = 1'b1;
      lat = -1; ackv = 2'b00; rd = 32'h0; e = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge ACLK);
         if (ack != 2'b00) begin
            lat = c; ackv = ack; rd = rdata; e = err;
            break;
         end
      end
      req[idx] = 1'b0;
   endtask

   // Both requests already raised; collect the two acks, dropping each req on its ack.
   task automatic run_pair(output logic [1:0] a1, output int t1,
                           output logic [1:0] a2, output int t2);
      int got;
      got = 0; a1 = 2'b00; a2 = 2'b00; t1 = -1; t2 = -1;
      for (int c = 1; c <= 40 && got < 2; c++) begin
         @(negedge ACLK);
         if (ack != 2'b00) begin
            if (got == 0) begin a1 = ack; t1 = c; end
            else          begin a2 = ack; t2 = c; end
            req = req & ~ack;
            got++;
         end
      end
      req = 2'b00;
   endtask

   task automatic test_reset;
      ARESETN = 1'b0;
      req = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge ACLK);
      n_cmp++;
      if ({ack, busy, err} !== 4'b0000) begin
         n_err++; $display("FAIL reset_ack_busy_err: got %b expected 0000", {ack, busy, err});
      end
      n_cmp++;
      if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b00000) begin
         n_err++; $display("FAIL reset_handshakes: got %b expected 00000",
                           {AWVALID, WVALID, BREADY, ARVALID, RREADY});
      end
      n_cmp++;
      if ({AWADDR, ARADDR, WDATA, rdata} !== 72'h0) begin
         n_err++; $display("FAIL reset_addr_data: got %h expected 0", {AWADDR, ARADDR, WDATA, rdata});
      end
      n_cmp++;
      if ({AWPROT, ARPROT, WSTRB} !== 10'b000_000_1111) begin
         n_err++; $display("FAIL const_prot_strb: got %b expected 0000001111", {AWPROT, ARPROT, WSTRB});
      end
      ARESETN = 1'b1;
      @(negedge ACLK);
   endtask

   task automatic test_write_read;
      int lat; logic [1:0] av; logic [31:0] rd; logic e;
      req_we[0] = 1'b1; req_addr[0] = 4'h0; req_wdata[0] = 32'h00000001; req[0] = 1'b1;
      @(negedge ACLK);
      n_cmp++;
      if ({AWVALID, WVALID, busy, AWADDR, WDATA} !== {3'b111, 4'h0, 32'h00000001}) begin
         n_err++; $display("FAIL wr_n1_valids: got %b/%h/%h expected 111/0/00000001",
                           {AWVALID, WVALID, busy}, AWADDR, WDATA);
      end
      @(negedge ACLK);
      n_cmp++;
      if ({AWVALID, WVALID, BREADY} !== 3'b001) begin
         n_err++; $display("FAIL wr_n2_bready: got %b expected 001", {AWVALID, WVALID, BREADY});
      end
      @(negedge ACLK);
      n_cmp++;
      if ({ack, err} !== 3'b010) begin
         n_err++; $display("FAIL wr_n3_ack: got %b expected 010", {ack, err});
      end
      req[0] = 1'b0;
      @(negedge ACLK);
      run_txn(0, 1'b0, 4'h0, 32'h0, lat, av, rd, e);
      n_cmp++;
      if (lat !== 3 || av !== 2'b01) begin
         n_err++; $display("FAIL rd_latency: got lat %0d ack %b expected lat 3 ack 01", lat, av);
      end
      n_cmp++;
      if ({rd, e} !== {32'h00000001, 1'b0}) begin
         n_err++; $display("FAIL rd_data: got %h err %b expected 00000001 err 0", rd, e);
      end
      @(negedge ACLK);
   endtask

   task automatic test_tie;
      int lat, t1, t2; logic [1:0] av, a1, a2; logic [31:0] rd; logic e;
      ARESETN = 1'b0;
      req_we = 2'b11; req_addr[0] = 4'h4; req_addr[1] = 4'h4;
      req_wdata[0] = 32'hA5A5A5A5; req_wdata[1] = 32'h5A5A5A5A; req = 2'b11;
      @(negedge ACLK);
      ARESETN = 1'b1;
      run_pair(a1, t1, a2, t2);
      n_cmp++;
      if (a1 !== 2'b01 || t1 !== 3) begin
         n_err++; $display("FAIL tie_first: got ack %b at %0d expected 01 at 3", a1, t1);
      end
      n_cmp++;
      if (a2 !== 2'b10 || t2 !== 7) begin
         n_err++; $display("FAIL tie_second_b2b: got ack %b at %0d expected 10 at 7", a2, t2);
      end
      @(negedge ACLK);
      run_txn(1, 1'b0, 4'h4, 32'h0, lat, av, rd, e);
      n_cmp++;
      if ({av, rd, e} !== {2'b10, 32'h5A5A5A5A, 1'b0}) begin
         n_err++; $display("FAIL tie_readback: got ack %b data %h err %b expected 10 5a5a5a5a 0", av, rd, e);
      end
      @(negedge ACLK);
      req_we = 2'b00; req_addr[0] = 4'h0; req_addr[1] = 4'h4; req = 2'b11;
      run_pair(a1, t1, a2, t2);
      n_cmp++;
      if (a1 !== 2'b01 || a2 !== 2'b10) begin
         n_err++; $display("FAIL tie_again: got order %b then %b expected 01 then 10", a1, a2);
      end
      @(negedge ACLK);
   endtask

   task automatic test_misaligned;
      int lat; logic [1:0] av; logic e; logic saw;
      saw = 1'b0; lat = -1; av = 2'b00; e = 1'b0;
      req_we[1] = 1'b0; req_addr[1] = 4'h6; req[1] = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge ACLK);
         saw = saw | AWVALID | ARVALID | WVALID;
         if (ack != 2'b00 && lat < 0) begin
            lat = c; av = ack; e = err; req[1] = 1'b0;
         end
      end
      n_cmp++;
      if (lat !== 1 || av !== 2'b10 || e !== 1'b1) begin
         n_err++; $display("FAIL misaligned_ack: got lat %0d ack %b err %b expected 1 10 1", lat, av, e);
      end
      n_cmp++;
      if (saw !== 1'b0) begin
         n_err++; $display("FAIL misaligned_no_axi: got valid seen %b expected 0", saw);
      end
   endtask

   task automatic test_aw_delay;
      int lat; logic [1:0] av; logic [31:0] rd; logic e; logic [2:0] exp_v;
      aw_delay = 3;
      lat = -1;
      req_we[0] = 1'b1; req_addr[0] = 4'h8; req_wdata[0] = 32'hDEADBEEF; req[0] = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge ACLK);
         if (c <= 5) begin
            exp_v = (c == 1) ? 3'b110 : (c == 5) ? 3'b001 : 3'b100;
            n_cmp++;
            if ({AWVALID, WVALID, BREADY} !== exp_v || AWADDR !== 4'h8) begin
               n_err++; $display("FAIL aw_delay_cycle%0d: got %b addr %h expected %b addr 8",
                                 c, {AWVALID, WVALID, BREADY}, AWADDR, exp_v);
            end
         end
         if (ack != 2'b00) begin
            lat = c;
            break;
         end
      end
      req[0] = 1'b0;
      aw_delay = 0;
      n_cmp++;
      if (lat !== 6) begin
         n_err++; $display("FAIL aw_delay_latency: got %0d expected 6", lat);
      end
      @(negedge ACLK);
      run_txn(0, 1'b0, 4'h8, 32'h0, lat, av, rd, e);
      n_cmp++;
      if ({rd, e} !== {32'hDEADBEEF, 1'b0}) begin
         n_err++; $display("FAIL aw_delay_readback: got %h err %b expected deadbeef 0", rd, e);
      end
      @(negedge ACLK);
   endtask

   task automatic test_slverr;
      int lat; logic [1:0] av; logic [31:0] rd; logic e;
      slv_err = 1'b1;
      run_txn(1, 1'b1, 4'hC, 32'hCAFEF00D, lat, av, rd, e);
      n_cmp++;
      if ({av, e} !== 3'b101 || lat !== 3) begin
         n_err++; $display("FAIL slverr_write: got ack %b err %b lat %0d expected 10 1 3", av, e, lat);
      end
      @(negedge ACLK);
      run_txn(0, 1'b0, 4'hC, 32'h0, lat, av, rd, e);
      n_cmp++;
      if ({av, rd, e} !== {2'b01, 32'h12345678, 1'b1}) begin
         n_err++; $display("FAIL slverr_read: got ack %b data %h err %b expected 01 12345678 1", av, rd, e);
      end
      slv_err = 1'b0;
      @(negedge ACLK);
   endtask

   task automatic test_reset_mid;
      int lat; logic [1:0] av; logic [31:0] rd; logic e;
      req_we[0] = 1'b0; req_addr[0] = 4'h4; req[0] = 1'b1;
      repeat (2) @(negedge ACLK);
      n_cmp++;
      if (RREADY !== 1'b1) begin
         n_err++; $display("FAIL mid_in_rd_r: got rready %b expected 1", RREADY);
      end
      ARESETN = 1'b0;
      @(negedge ACLK);
      n_cmp++;
      if ({ack, busy, err, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 9'b0) begin
         n_err++; $display("FAIL mid_reset_ctrl: got %b expected 000000000",
                           {ack, busy, err, AWVALID, WVALID, BREADY, ARVALID, RREADY});
      end
      n_cmp++;
      if ({rdata, ARADDR} !== 36'h0) begin
         n_err++; $display("FAIL mid_reset_data: got rdata %h araddr %h expected 0 0", rdata, ARADDR);
      end
      ARESETN = 1'b1;
      lat = -1; av = 2'b00; rd = 32'hFFFFFFFF; e = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge ACLK);
         if (ack != 2'b00) begin
            lat = c; av = ack; rd = rdata; e = err;
            break;
         end
      end
      req[0] = 1'b0;
      n_cmp++;
      if (lat !== 3 || {av, rd, e} !== {2'b01, 32'h0, 1'b0}) begin
         n_err++; $display("FAIL mid_rearb: got lat %0d ack %b data %h err %b expected 3 01 0 0",
                           lat, av, rd, e);
      end
      @(negedge ACLK);
   endtask

   initial begin
      ARESETN = 1'b0;
      req = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
      test_reset;
      test_write_read;
      test_tie;
      test_misaligned;
      test_aw_delay;
      test_slverr;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
